// File: rtl/sprattr_scan_pkg.sv
// Shared definitions for the sprite attribute table and its line scan engine.
package sprattr_scan_pkg;

  // io register window
  localparam logic [3:0] A_SEL  = 4'h4;
  localparam logic [3:0] A_XL   = 4'h5;
  localparam logic [3:0] A_XH   = 4'h6;
  localparam logic [3:0] A_Y    = 4'h7;
  localparam logic [3:0] A_IDX  = 4'h8;
  localparam logic [3:0] A_ATTR = 4'h9;
  localparam logic [3:0] A_CTRL = 4'hA;

  // ATTR byte layout; bit0 carries idx[8]
  localparam int AB_EN     = 7;
  localparam int AB_PRI    = 6;
  localparam int AB_PAL_HI = 5;
  localparam int AB_PAL_LO = 4;
  localparam int AB_H16    = 3;
  localparam int AB_VF     = 2;
  localparam int AB_HF     = 1;
  localparam int AB_IDX8   = 0;

  // sprite heights
  localparam logic [7:0] H_SMALL = 8'd8;
  localparam logic [7:0] H_TALL  = 8'd16;

  // one table entry, 33 bits
  typedef struct packed {
    logic       enable;
    logic       prio;
    logic [1:0] palette;
    logic       h16;
    logic       vflip;
    logic       hflip;
    logic [8:0] idx;
    logic [7:0] y;
    logic [8:0] x;
  } spr_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_EMIT,
    S_DONE
  } scan_st_t;

  // reassemble the ATTR register view of an entry
  function automatic logic [7:0] attr_byte(input spr_entry_t e);
    return {e.enable, e.prio, e.palette, e.h16, e.vflip, e.hflip, e.idx[8]};
  endfunction

endpackage

// File: rtl/sprattr_ram.sv
// Sprite entry storage: byte-lane writes from the CPU, two async read ports.
module sprattr_ram
  import sprattr_scan_pkg::*;
#(
  parameter int NUM_SPR = 64,
  parameter int SEL_W   = $clog2(NUM_SPR)
) (
  input  logic             clk,
  input  logic [SEL_W-1:0] cpu_sel,
  input  logic [7:0]       wdata,
  input  logic             we_xl,
  input  logic             we_xh,
  input  logic             we_y,
  input  logic             we_idx,
  input  logic             we_attr,
  output spr_entry_t       cpu_rd,
  input  logic [SEL_W-1:0] scan_sel,
  output spr_entry_t       scan_rd
);

  spr_entry_t mem [NUM_SPR];

  // field writes land on the selected entry; contents are never reset
  always_ff @(posedge clk) begin
    if (we_xl)  mem[cpu_sel].x[7:0]   <= wdata;
    if (we_xh)  mem[cpu_sel].x[8]     <= wdata[0];
    if (we_y)   mem[cpu_sel].y        <= wdata;
    if (we_idx) mem[cpu_sel].idx[7:0] <= wdata;
    if (we_attr) begin
      mem[cpu_sel].idx[8]  <= wdata[AB_IDX8];
      mem[cpu_sel].enable  <= wdata[AB_EN];
      mem[cpu_sel].prio    <= wdata[AB_PRI];
      mem[cpu_sel].palette <= wdata[AB_PAL_HI:AB_PAL_LO];
      mem[cpu_sel].h16     <= wdata[AB_H16];
      mem[cpu_sel].vflip   <= wdata[AB_VF];
      mem[cpu_sel].hflip   <= wdata[AB_HF];
    end
  end

  // reads see the pre-edge contents, so a same-cycle write is invisible to the scan
  assign cpu_rd  = mem[cpu_sel];
  assign scan_rd = mem[scan_sel];

endmodule

// File: rtl/sprattr_scan.sv
// Sprite attribute table with CPU register window and per-line scan engine.
module sprattr_scan
  import sprattr_scan_pkg::*;
#(
  parameter int NUM_SPR  = 64,
  parameter int SEL_W    = $clog2(NUM_SPR),
  parameter int MAX_LINE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       io_addr,
  input  logic [7:0]       io_wrdata,
  input  logic             io_wren,
  output logic [7:0]       io_rddata,
  input  logic             scan_start,
  input  logic [7:0]       scan_line,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             scan_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic [8:0]       out_x,
  output logic [8:0]       out_idx,
  output logic [3:0]       out_row,
  output logic             out_priority,
  output logic             out_hflip,
  output logic [1:0]       out_palette,
  output logic             out_h16
);

  localparam int              CNT_W   = $clog2(MAX_LINE + 1);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(NUM_SPR - 1);
  localparam logic [CNT_W-1:0] CNT_LST = CNT_W'(MAX_LINE - 1);

  logic [SEL_W-1:0] sel;
  logic             auto_inc;

  logic we_xl, we_xh, we_y, we_idx, we_attr;
  spr_entry_t cpu_rd, scan_rd;

  scan_st_t         st;
  logic [7:0]       line_q;
  logic [SEL_W-1:0] scan_i;
  logic [CNT_W-1:0] cnt;
  logic             full;

  logic [7:0] row;
  logic [7:0] hgt;
  logic       hit;
  logic [3:0] eff_row;

  assign we_xl   = io_wren && (io_addr == A_XL);
  assign we_xh   = io_wren && (io_addr == A_XH);
  assign we_y    = io_wren && (io_addr == A_Y);
  assign we_idx  = io_wren && (io_addr == A_IDX);
  assign we_attr = io_wren && (io_addr == A_ATTR);

  sprattr_ram #(
    .NUM_SPR (NUM_SPR),
    .SEL_W   (SEL_W)
  ) u_ram (
    .clk      (clk),
    .cpu_sel  (sel),
    .wdata    (io_wrdata),
    .we_xl    (we_xl),
    .we_xh    (we_xh),
    .we_y     (we_y),
    .we_idx   (we_idx),
    .we_attr  (we_attr),
    .cpu_rd   (cpu_rd),
    .scan_sel (scan_i),
    .scan_rd  (scan_rd)
  );

  // select and control registers; ATTR writes optionally step the select
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel      <= '0;
      auto_inc <= 1'b0;
    end else if (io_wren) begin
      case (io_addr)
        A_SEL:  sel      <= io_wrdata[SEL_W-1:0];
        A_CTRL: auto_inc <= io_wrdata[0];
        A_ATTR: if (auto_inc) sel <= sel + 1'b1;
        default: ;
      endcase
    end
  end

  // combinational register read-back
  always_comb begin
    io_rddata = 8'h00;
    case (io_addr)
      A_SEL:  io_rddata = 8'(sel);
      A_XL:   io_rddata = cpu_rd.x[7:0];
      A_XH:   io_rddata = {7'b0, cpu_rd.x[8]};
      A_Y:    io_rddata = cpu_rd.y;
      A_IDX:  io_rddata = cpu_rd.idx[7:0];
      A_ATTR: io_rddata = attr_byte(cpu_rd);
      A_CTRL: io_rddata = {7'b0, auto_inc};
      default: io_rddata = 8'h00;
    endcase
  end

  // vertical hit test of the entry under evaluation; row wraps mod 256
  always_comb begin
    row     = line_q - scan_rd.y;
    hgt     = scan_rd.h16 ? H_TALL : H_SMALL;
    hit     = scan_rd.enable && (row < hgt);
    // h-1-row in 4 bits: 16 truncates to 0, so 0-1-row == 15-row
    eff_row = scan_rd.vflip ? (hgt[3:0] - 4'd1 - row[3:0]) : row[3:0];
  end

  // scan FSM: one entry per EVAL cycle, EMIT holds a stream entry until taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st           <= S_IDLE;
      line_q       <= '0;
      scan_i       <= '0;
      cnt          <= '0;
      full         <= 1'b0;
      scan_busy    <= 1'b0;
      scan_done    <= 1'b0;
      scan_ovf     <= 1'b0;
      out_valid    <= 1'b0;
      out_sel      <= '0;
      out_x        <= '0;
      out_idx      <= '0;
      out_row      <= '0;
      out_priority <= 1'b0;
      out_hflip    <= 1'b0;
      out_palette  <= '0;
      out_h16      <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (scan_start) begin
            line_q    <= scan_line;
            scan_ovf  <= 1'b0;
            cnt       <= '0;
            full      <= 1'b0;
            scan_i    <= '0;
            scan_busy <= 1'b1;
            st        <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (hit && full) begin
            // line budget spent and another sprite wants this line
            scan_ovf <= 1'b1;
            st       <= S_DONE;
          end else if (hit) begin
            out_sel      <= scan_i;
            out_x        <= scan_rd.x;
            out_idx      <= scan_rd.idx;
            out_row      <= eff_row;
            out_priority <= scan_rd.prio;
            out_hflip    <= scan_rd.hflip;
            out_palette  <= scan_rd.palette;
            out_h16      <= scan_rd.h16;
            out_valid    <= 1'b1;
            st           <= S_EMIT;
          end else if (scan_i == LAST) begin
            st <= S_DONE;
          end else begin
            scan_i <= scan_i + 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= cnt + 1'b1;
            if (scan_i == LAST) begin
              st <= S_DONE;
            end else begin
              // after the last permitted emit, keep walking only to detect overflow
              if (cnt == CNT_LST) full <= 1'b1;
              scan_i <= scan_i + 1'b1;
              st     <= S_EVAL;
            end
          end
        end
        S_DONE: begin
          scan_done <= 1'b1;
          scan_busy <= 1'b0;
          st        <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprattr_scan.sv
// Directed bench for sprattr_scan with a behavioural table/scan model.
module tb_sprattr_scan;

  localparam int N  = 64;
  localparam int SW = $clog2(N);
  localparam int ML = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    io_addr;
  logic [7:0]    io_wrdata;
  logic          io_wren;
  logic [7:0]    io_rddata;
  logic          scan_start;
  logic [7:0]    scan_line;
  logic          scan_busy, scan_done, scan_ovf;
  logic          out_valid, out_ready;
  logic [SW-1:0] out_sel;
  logic [8:0]    out_x, out_idx;
  logic [3:0]    out_row;
  logic          out_priority, out_hflip, out_h16;
  logic [1:0]    out_palette;

  sprattr_scan #(.NUM_SPR(N), .MAX_LINE(ML)) dut (
    .clk(clk), .reset_n(reset_n),
    .io_addr(io_addr), .io_wrdata(io_wrdata), .io_wren(io_wren), .io_rddata(io_rddata),
    .scan_start(scan_start), .scan_line(scan_line),
    .scan_busy(scan_busy), .scan_done(scan_done), .scan_ovf(scan_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_x(out_x), .out_idx(out_idx), .out_row(out_row),
    .out_priority(out_priority), .out_hflip(out_hflip),
    .out_palette(out_palette), .out_h16(out_h16)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  typedef struct {
    int sel; int x; int idx; int row; int pri; int hf; int pal; int h16;
  } em_t;

  em_t exp_q[$];
  em_t log_q[$];
  int  exp_ovf;

  // model of the table and register window
  logic [8:0]    m_x   [N];
  logic [7:0]    m_y   [N];
  logic [8:0]    m_idx [N];
  logic [7:0]    m_attr[N];
  logic [SW-1:0] m_sel;
  logic          m_ctrl;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_rd(input logic [3:0] a);
    case (a)
      4'h4: return int'(m_sel);
      4'h5: return int'(m_x[m_sel][7:0]);
      4'h6: return int'(m_x[m_sel][8]);
      4'h7: return int'(m_y[m_sel]);
      4'h8: return int'(m_idx[m_sel][7:0]);
      4'h9: return int'({m_attr[m_sel][7:1], m_idx[m_sel][8]});
      4'hA: return int'(m_ctrl);
      default: return 0;
    endcase
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    io_addr = a; io_wrdata = d; io_wren = 1'b1;
    @(posedge clk); #1;
    io_wren = 1'b0;
    case (a)
      4'h4: m_sel = d[SW-1:0];
      4'h5: m_x[m_sel][7:0] = d;
      4'h6: m_x[m_sel][8] = d[0];
      4'h7: m_y[m_sel] = d;
      4'h8: m_idx[m_sel][7:0] = d;
      4'h9: begin
        m_attr[m_sel] = d; m_idx[m_sel][8] = d[0];
        if (m_ctrl) m_sel = m_sel + 1'b1;
      end
      4'hA: m_ctrl = d[0];
      default: ;
    endcase
  endtask

  // read against the model, and optionally against a hand-computed literal
  task automatic rd(input logic [3:0] a, input int lit, input bit use_lit, input string nm);
    io_addr = a; io_wren = 1'b0;
    #1;
    chk({nm, "_model"}, int'(io_rddata), model_rd(a));
    if (use_lit) chk(nm, int'(io_rddata), lit);
  endtask

  task automatic set_spr(input int n, input logic [8:0] x, input logic [7:0] y,
                         input logic [8:0] idx, input logic [7:0] attr);
    wr(4'h4, 8'(n));
    wr(4'h5, x[7:0]);
    wr(4'h6, {7'b0, x[8]});
    wr(4'h7, y);
    wr(4'h8, idx[7:0]);
    wr(4'h9, {attr[7:1], idx[8]});
  endtask

  // expected stream for one line, straight from the visibility rules
  task automatic build_exp(input logic [7:0] line);
    int nm, r, h;
    em_t e;
    exp_q.delete(); log_q.delete();
    exp_ovf = 0; nm = 0;
    for (int n = 0; n < N; n++) begin
      r = (int'(line) - int'(m_y[n])) & 255;
      h = m_attr[n][3] ? 16 : 8;
      if (m_attr[n][7] && r < h) begin
        if (nm < ML) begin
          e.sel = n; e.x = int'(m_x[n]); e.idx = int'(m_idx[n]);
          e.row = m_attr[n][2] ? (h - 1 - r) : r;
          e.pri = int'(m_attr[n][6]); e.hf = int'(m_attr[n][1]);
          e.pal = int'(m_attr[n][5:4]); e.h16 = int'(m_attr[n][3]);
          exp_q.push_back(e);
        end else begin
          exp_ovf = 1;
        end
        nm++;
      end
    end
  endtask

  task automatic run_scan(input logic [7:0] line, input int stall, output int cyc);
    int left;
    build_exp(line);
    left = stall;
    @(posedge clk); #1;
    scan_start = 1'b1; scan_line = line; out_ready = (stall == 0);
    @(posedge clk); #1;
    scan_start = 1'b0;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk); cyc++; #1;
      if (left > 0) begin
        out_ready = 1'b0;
        if (out_valid) left--;
      end else begin
        out_ready = 1'b1;
      end
      if (scan_done) break;
    end
    if (cyc >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL scan_timeout: no scan_done within %0d cycles", cyc);
    end
    @(negedge clk); #1;
  endtask

  // stream checker: every valid cycle must present the model's head entry
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexp_valid: sel %0d emitted, none expected", out_sel);
        end else begin
          chk("out_sel", int'(out_sel), exp_q[0].sel);
          chk("out_x", int'(out_x), exp_q[0].x);
          chk("out_idx", int'(out_idx), exp_q[0].idx);
          chk("out_row", int'(out_row), exp_q[0].row);
          chk("out_pri", int'(out_priority), exp_q[0].pri);
          chk("out_hflip", int'(out_hflip), exp_q[0].hf);
          chk("out_pal", int'(out_palette), exp_q[0].pal);
          chk("out_h16", int'(out_h16), exp_q[0].h16);
          if (out_ready) void'(exp_q.pop_front());
        end
        if (out_ready)
          log_q.push_back('{int'(out_sel), int'(out_x), int'(out_idx), int'(out_row),
                            int'(out_priority), int'(out_hflip), int'(out_palette), int'(out_h16)});
      end
      if (scan_done) begin
        done_cnt++;
        chk("leftover", exp_q.size(), 0);
        chk("scan_ovf", int'(scan_ovf), exp_ovf);
        chk("busy_at_done", int'(scan_busy), 0);
      end
    end
  end

  initial begin
    int cyc, d0, t;
    reset_n = 1'b0; io_addr = '0; io_wrdata = '0; io_wren = 1'b0;
    scan_start = 1'b0; scan_line = '0; out_ready = 1'b1;
    m_sel = '0; m_ctrl = 1'b0;
    for (int n = 0; n < N; n++) begin
      m_x[n] = '0; m_y[n] = '0; m_idx[n] = '0; m_attr[n] = '0;
    end
    #23 reset_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_busy", int'(scan_busy), 0);
    chk("rst_done", int'(scan_done), 0);
    chk("rst_ovf", int'(scan_ovf), 0);
    chk("rst_valid", int'(out_valid), 0);
    rd(4'h4, 0, 1, "rst_sel");
    rd(4'hA, 0, 1, "rst_ctrl");

    // register window
    wr(4'h4, 8'h05);
    wr(4'h5, 8'h34); wr(4'h6, 8'h01); wr(4'h7, 8'h20);
    wr(4'h8, 8'h7F); wr(4'h9, 8'h81);
    rd(4'h5, 8'h34, 1, "rd_xl");
    rd(4'h6, 8'h01, 1, "rd_xh");
    rd(4'h7, 8'h20, 1, "rd_y");
    rd(4'h8, 8'h7F, 1, "rd_idx");
    rd(4'h9, 8'h81, 1, "rd_attr");
    rd(4'h4, 8'h05, 1, "rd_sel");
    rd(4'hB, 8'h00, 1, "rd_undef");
    wr(4'h6, 8'hFF);
    rd(4'h6, 8'h01, 1, "rd_xh_mask");
    wr(4'h4, 8'hC5);
    rd(4'h4, 8'h05, 1, "rd_sel_mask");

    // auto-increment wrap and hold
    wr(4'hA, 8'h01);
    rd(4'hA, 8'h01, 1, "rd_ctrl");
    wr(4'h4, 8'(N - 1));
    wr(4'h9, 8'h00);
    rd(4'h4, 8'h00, 1, "autoinc_wrap");
    wr(4'hA, 8'h00);
    wr(4'h4, 8'h09);
    wr(4'h9, 8'h00);
    rd(4'h4, 8'h09, 1, "autoinc_off");

    // disable every entry, walking the table with auto-increment
    wr(4'hA, 8'h01); wr(4'h4, 8'h00);
    for (int n = 0; n < N; n++) wr(4'h9, 8'h00);
    rd(4'h4, 8'h00, 1, "clear_wrap");
    wr(4'hA, 8'h00);

    // basic scan
    set_spr(3, 9'h1AB, 8'd10, 9'h155, 8'hE2);
    set_spr(7, 9'h012, 8'd12, 9'h0AA, 8'h9C);
    d0 = done_cnt;
    run_scan(8'd14, 0, cyc);
    chk("basic_lat", cyc, N + 3);
    chk("basic_done", done_cnt - d0, 1);
    chk("basic_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("basic_sel0", log_q[0].sel, 3);
      chk("basic_row0", log_q[0].row, 4);
      chk("basic_x0", log_q[0].x, 'h1AB);
      chk("basic_sel1", log_q[1].sel, 7);
      chk("basic_row1", log_q[1].row, 13);
    end
    set_spr(3, 9'h0, 8'd0, 9'h0, 8'h00);
    set_spr(7, 9'h0, 8'd0, 9'h0, 8'h00);

    // Y wrap with backpressure
    set_spr(20, 9'h0F0, 8'd250, 9'h1FF, 8'h88);
    d0 = done_cnt;
    run_scan(8'd3, 5, cyc);
    chk("wrap_lat", cyc, N + 7);
    chk("wrap_done", done_cnt - d0, 1);
    chk("wrap_n", log_q.size(), 1);
    if (log_q.size() == 1) chk("wrap_row", log_q[0].row, 9);

    // height boundary: last row matches, one past does not
    run_scan(8'd9, 0, cyc);
    chk("edge_in_n", log_q.size(), 1);
    if (log_q.size() == 1) chk("edge_in_row", log_q[0].row, 15);
    run_scan(8'd10, 0, cyc);
    chk("nomatch_lat", cyc, N + 1);
    chk("nomatch_n", log_q.size(), 0);
    set_spr(20, 9'h0, 8'd0, 9'h0, 8'h00);

    // overflow
    for (int n = 0; n < 20; n++) set_spr(n, 9'(n), 8'd0, 9'(n), 8'h80);
    d0 = done_cnt;
    run_scan(8'd0, 0, cyc);
    chk("ovf_done", done_cnt - d0, 1);
    chk("ovf_n", log_q.size(), 16);
    for (int k = 0; k < log_q.size(); k++) chk("ovf_sel", log_q[k].sel, k);
    chk("ovf_flag", int'(scan_ovf), 1);

    // reset in the middle of an emit
    build_exp(8'd0);
    @(posedge clk); #1;
    scan_start = 1'b1; scan_line = 8'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    scan_start = 1'b0;
    t = 0;
    while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
    chk("rst_mid_reached", int'(out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_busy", int'(scan_busy), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_sel = '0; m_ctrl = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    run_scan(8'd0, 0, cyc);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_n", log_q.size(), 16);
    if (log_q.size() > 0) chk("post_rst_sel0", log_q[0].sel, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
